// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared defaults and types for the register-file write-port arbiter.
//   DEF_DATA_W / DEF_REG_W : default data and register-address widths
//   R_ZERO                 : hard-wired zero register, never written
//   wr_sel_e               : source chosen for the next register-file write
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int R_ZERO     = 0;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WB   = 2'd1,
    SEL_HEAD = 2'd2
  } wr_sel_e;

endpackage

// File: rtl/wb_side_fifo.sv
// -----------------------------------------------------------------------------
// wb_side_fifo
// Circular buffer of side-unit results waiting for a free write-port slot.
// Each entry holds {kill, rd, data}. A kill port marks every stored entry whose
// rd matches, so an older side result cannot overwrite a newer pipeline write.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   push, push_rd/data    store a new entry (caller guarantees not full)
//   pop                   drop the head entry (caller guarantees not empty)
//   kill_en, kill_rd      set kill on every stored entry with rd == kill_rd
//   head_rd/data/kill     current head entry
//   count                 entries held
// -----------------------------------------------------------------------------
module wb_side_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [REG_W-1:0]         push_rd,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [REG_W-1:0]         kill_rd,
  output logic [REG_W-1:0]         head_rd,
  output logic [DATA_W-1:0]        head_data,
  output logic                     head_kill,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DEPTH-1:0]  kill_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      kill_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      // Stale slots may also be marked; a push always rewrites its slot's kill
      // bit below, and that later assignment wins.
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_q[i] == kill_rd) kill_q[i] <= 1'b1;
        end
      end
      if (push) begin
        data_q[wr_ptr] <= push_data;
        rd_q[wr_ptr]   <= push_rd;
        kill_q[wr_ptr] <= 1'b0;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_rd   = rd_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_kill = kill_q[rd_ptr];
  assign count     = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && cnt_q == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && cnt_q == '0));

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single register-file write port between the pipeline WB stage and
// the multi-cycle side unit. WB has priority; side results queue in a small
// buffer and drain in idle WB slots. If a live side result waits STARVE_LIMIT
// cycles, a one-cycle pipeline stall is forced so it retires.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   wb_valid, wb_rd, wb_data        WB-stage write request
//   side_valid, side_rd, side_data  side-unit result offer
//   side_ready                      buffer can accept a side result
//   stall_pipe                      freeze pipeline this cycle (WB ignored)
//   rf_we, rf_waddr, rf_wdata       registered register-file write port
//   fifo_count                      side entries buffered
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REG_W        = DEF_REG_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_valid,
  input  logic [REG_W-1:0]             wb_rd,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic                         side_valid,
  output logic                         side_ready,
  input  logic [REG_W-1:0]             side_rd,
  input  logic [DATA_W-1:0]            side_data,
  output logic                         stall_pipe,
  output logic                         rf_we,
  output logic [REG_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [REG_W-1:0] RD_ZERO = REG_W'(R_ZERO);

  logic              wb_req;
  logic              wb_win;
  logic              push_acc;
  logic              push_store;
  logic              pop;
  logic              fifo_nonempty;
  logic [REG_W-1:0]  head_rd;
  logic [DATA_W-1:0] head_data;
  logic              head_kill;
  wr_sel_e           sel;
  logic              stall_q;
  logic [STV_W-1:0]  starve_left;

  assign side_ready    = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push_acc      = side_valid & side_ready;
  // r0 results are accepted (handshake completes) but never stored.
  assign push_store    = push_acc & (side_rd != RD_ZERO);
  assign wb_req        = wb_valid & (wb_rd != RD_ZERO);
  assign fifo_nonempty = (fifo_count != '0);
  assign wb_win        = ~stall_q & wb_req;
  assign stall_pipe    = stall_q;

  wb_side_fifo #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_store),
    .push_rd   (side_rd),
    .push_data (side_data),
    .pop       (pop),
    .kill_en   (wb_win),
    .kill_rd   (wb_rd),
    .head_rd   (head_rd),
    .head_data (head_data),
    .head_kill (head_kill),
    .count     (fifo_count)
  );

  // A killed head is discarded in any cycle it is at the head, even while WB
  // owns the port; only one entry leaves per cycle.
  always_comb begin
    sel = SEL_NONE;
    pop = 1'b0;
    if (stall_q) begin
      pop = fifo_nonempty;
      if (fifo_nonempty && !head_kill) sel = SEL_HEAD;
    end else if (wb_req) begin
      sel = SEL_WB;
      pop = fifo_nonempty & head_kill;
    end else if (fifo_nonempty) begin
      pop = 1'b1;
      if (!head_kill) sel = SEL_HEAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (sel)
        SEL_WB: begin
          rf_we    <= 1'b1;
          rf_waddr <= wb_rd;
          rf_wdata <= wb_data;
        end
        SEL_HEAD: begin
          rf_we    <= 1'b1;
          rf_waddr <= head_rd;
          rf_wdata <= head_data;
        end
        default: begin
          rf_we    <= 1'b0;
          rf_waddr <= '0;
          rf_wdata <= '0;
        end
      endcase
    end
  end

  // Wait budget counts down from STARVE_LIMIT; a live head that is not popped
  // consumes one unit per cycle. Hitting the last unit raises stall for one
  // cycle and reloads, so later waiters start a fresh budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= 1'b0;
      starve_left <= STV_W'(STARVE_LIMIT);
    end else begin
      stall_q <= 1'b0;
      if (!fifo_nonempty || pop) begin
        starve_left <= STV_W'(STARVE_LIMIT);
      end else if (starve_left == STV_W'(1)) begin
        stall_q     <= 1'b1;
        starve_left <= STV_W'(STARVE_LIMIT);
      end else begin
        starve_left <= starve_left - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk;
  logic          rst_n;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          side_valid;
  logic          side_ready;
  logic [RW-1:0] side_rd;
  logic [DW-1:0] side_data;
  logic          stall_pipe;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [1:0]    fifo_count;

  wb_port_arbiter #(
    .DATA_W       (DW),
    .REG_W        (RW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .side_valid (side_valid),
    .side_ready (side_ready),
    .side_rd    (side_rd),
    .side_data  (side_data),
    .stall_pipe (stall_pipe),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
    bit            kill;
  } ent_t;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  ent_t mq[$];      // reference side buffer, oldest first
  wr_t  exp_q[$];   // scoreboard of expected register-file writes
  bit   m_stall;
  int   m_starve;
  bit            h_wv;
  logic [RW-1:0] h_wrd;
  logic [DW-1:0] h_wd;
  logic [DW-1:0] mon_rf [32];
  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every DUT write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write at %0t",
                 rf_waddr, rf_wdata, $time);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, w.rd});
        chk("wr_data", rf_wdata, w.data);
      end
      mon_rf[rf_waddr] = rf_wdata;
    end
  end

  task automatic push_exp(input logic [RW-1:0] rd, input logic [DW-1:0] data);
    wr_t w;
    w.rd   = rd;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // One clock of stimulus plus the reference model's view of that clock.
  task automatic cycle(input bit wv, input logic [RW-1:0] wrd, input logic [DW-1:0] wd,
                       input bit sv, input logic [RW-1:0] srd, input logic [DW-1:0] sd);
    int   sz0;
    bit   ne;
    bit   popped;
    bit   old_kill;
    ent_t e;
    @(negedge clk);
    chk("stall_pipe", {31'd0, stall_pipe}, {31'd0, m_stall});
    chk("fifo_count", {30'd0, fifo_count}, mq.size());
    chk("side_ready", {31'd0, side_ready}, (mq.size() < DEPTH) ? 1 : 0);
    if (m_stall) begin
      wv  = h_wv;
      wrd = h_wrd;
      wd  = h_wd;
    end
    h_wv = wv; h_wrd = wrd; h_wd = wd;
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    side_valid = sv; side_rd = srd; side_data = sd;

    sz0 = mq.size();
    ne = (sz0 > 0);
    popped = 1'b0;
    if (m_stall) begin
      if (ne) begin
        e = mq.pop_front();
        popped = 1'b1;
        if (!e.kill) push_exp(e.rd, e.data);
      end
    end else if (wv && wrd != 0) begin
      old_kill = ne && mq[0].kill;
      push_exp(wrd, wd);
      foreach (mq[i]) if (mq[i].rd == wrd) mq[i].kill = 1'b1;
      if (old_kill) begin
        void'(mq.pop_front());
        popped = 1'b1;
      end
    end else if (ne) begin
      e = mq.pop_front();
      popped = 1'b1;
      if (!e.kill) push_exp(e.rd, e.data);
    end

    m_stall = 1'b0;
    if (!ne || popped) begin
      m_starve = 0;
    end else begin
      m_starve++;
      if (m_starve == LIMIT) begin
        m_stall  = 1'b1;
        m_starve = 0;
      end
    end

    if (sv && sz0 < DEPTH && srd != 0) begin
      e.rd = srd; e.data = sd; e.kill = 1'b0;
      mq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    side_valid = 0; side_rd = 0; side_data = 0;
    exp_q.delete();
    mq.delete();
    m_stall = 0; m_starve = 0;
    h_wv = 0; h_wrd = 0; h_wd = 0;
    @(posedge clk);
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 0);
    chk("rst_fifo_count", {30'd0, fifo_count}, 0);
    chk("rst_side_ready", {31'd0, side_ready}, 1);
    chk("rst_stall", {31'd0, stall_pipe}, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int  n_st;
    bit  acc;
    int  pw;
    int  ps;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 32; i++) mon_rf[i] = '0;
    rst_n = 1'b0;
    do_reset();

    // T1: reset while a WB write and a side push are in flight.
    cycle(1, 5'd4, 32'hDEAD, 1, 5'd6, 32'hBEEF);
    cycle(1, 5'd4, 32'hD00D, 0, 0, 0);
    do_reset();
    idle(4);

    // T2: idle drain.
    cycle(0, 0, 0, 1, 5'd5, 32'h1234);
    idle(4);

    // T3: WB busy every cycle, one side entry must retire via a forced stall.
    n_st = 0;
    cycle(1, 5'd3, 32'h300, 1, 5'd7, 32'h777);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 5'd3, 32'h301 + i, 0, 0, 0);
      if (stall_pipe) n_st++;
    end
    chk("t3_stall_count", n_st, 1);
    idle(3);

    // T4: fill the buffer while WB is busy; third result held until accepted.
    cycle(1, 5'd1, 32'h100, 1, 5'd10, 32'hA10);
    cycle(1, 5'd1, 32'h101, 1, 5'd11, 32'hA11);
    for (int i = 0; i < 12; i++) begin
      acc = (mq.size() < DEPTH);
      cycle(1, 5'd1, 32'h110 + i, 1, 5'd12, 32'hA12);
      if (i == 0) chk("t4_ready_low", {31'd0, side_ready}, 0);
      if (acc) break;
    end
    idle(6);

    // T5: WAW kill of a buffered result.
    cycle(0, 0, 0, 1, 5'd9, 32'hAA);
    cycle(1, 5'd9, 32'hBB, 0, 0, 0);
    idle(4);
    chk("t5_r9_final", mon_rf[9], 32'hBB);

    // T6: r0 requests from both sources.
    cycle(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
    chk("t6_ready", {31'd0, side_ready}, 1);
    idle(3);
    chk("t6_fifo_count", {30'd0, fifo_count}, 0);

    // Randomized traffic with varying WB load, and a reset in the middle.
    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 3 == 0) ? 30 : ((ph % 3 == 1) ? 65 : 95);
      ps = (ph % 2 == 0) ? 50 : 80;
      for (int i = 0; i < 150; i++) begin
        cycle($urandom_range(0, 99) < pw, 5'($urandom_range(0, 7)), $urandom(),
              $urandom_range(0, 99) < ps, 5'($urandom_range(0, 7)), $urandom());
      end
      if (ph == 2) do_reset();
    end

    idle(10);
    chk("exp_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
